// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit with HI/LO registers.
// Ports: clk, reset (sync, active-low), start/op/srca/srcb request an operation,
//   mthi/mtlo/wd write HI/LO directly, hi/lo results, busy while running, done pulse.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIXUP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [WIDTH-1:0]   r_srca;
  logic [WIDTH-1:0]   r_div;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_accept;
  logic               w_last;
  logic               w_is_div;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ok;
  logic [2*WIDTH-1:0] w_mstep;
  logic [2*WIDTH-1:0] w_dstep;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_accept = start && (r_state == S_IDLE);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_is_div = op[1];

  // op[0]==0 selects the signed variants
  assign w_sa    = ~op[0] & srca[WIDTH-1];
  assign w_sb    = ~op[0] & srcb[WIDTH-1];
  assign w_mag_a = w_sa ? (~srca + 1'b1) : srca;
  assign w_mag_b = w_sb ? (~srcb + 1'b1) : srcb;

  // multiply step: add multiplicand into upper half when LSB set, shift right
  assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + (r_acc[0] ? {1'b0, r_div} : '0);
  assign w_mstep = {w_msum, r_acc[WIDTH-1:1]};

  // restoring divide step: remainder in upper half, quotient shifts in below
  assign w_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_ok    = ~w_diff[WIDTH];
  assign w_dstep = {(w_ok ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], w_ok};

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1)
                          : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                          : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_dz) begin
        w_res_hi = r_srca;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_FIXUP;
      S_FIXUP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = r_done;
    hi   = r_hi;
    lo   = r_lo;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_srca   <= '0;
      r_div    <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIXUP);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_dz     <= (srcb == '0);
            r_srca   <= srca;
            r_div    <= w_is_div ? w_mag_b : w_mag_a;
            r_acc    <= {{WIDTH{1'b0}},
                         (w_is_div ? w_mag_a : w_mag_b)};
          end else begin
            if (mthi) r_hi <= wd;
            if (mtlo) r_lo <= wd;
          end
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_dstep : w_mstep;
          if (!w_last) r_cnt <= r_cnt + 1'b1;
        end
        S_FIXUP: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table plus
// hand sequences for start/mthi/reset corner cases.
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .srca(srca), .srcb(srcb), .mthi(mthi), .mtlo(mtlo),
    .wd(wd), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Waits (bounded) until busy drops; returns cycles seen busy
  // and number of done pulses seen while busy.
  task automatic wait_idle(output int n, output int dn);
    n = 0;
    dn = 0;
    while (busy === 1'b1 && n < 200) begin
      if (done === 1'b1) dn++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int n,
                        output int dn);
    @(negedge clk);
    op = o; srca = a; srcb = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = ~o; srca = ~a; srcb = ~b;
    wait_idle(n, dn);
  endtask

  int n, dn;

  initial begin
    vt[0]  = '{2'b00, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[1]  = '{2'b01, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE};
    vt[2]  = '{2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3]  = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14};
    vt[4]  = '{2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF};
    vt[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
    vt[6]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
    vt[7]  = '{2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vt[8]  = '{2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 32'hF};
    vt[9]  = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
    vt[10] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3};
    vt[11] = '{2'b10, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vt[12] = '{2'b01, 32'h10000, 32'h10000, 32'h1, 32'h0};
    vt[13] = '{2'b11, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF};
    vt[14] = '{2'b11, 32'h80000000, 32'h3, 32'h2, 32'h2AAAAAAA};

    reset = 1'b0; start = 1'b1; op = 2'b01;
    srca = 32'd3; srcb = 32'd3;
    mthi = 1'b0; mtlo = 1'b0; wd = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("rst_start_ignored", busy, 0);

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, n, dn);
      chk($sformatf("v%0d_busy_cycles", i), n, 33);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_hi", i), hi, vt[i].ehi);
      chk($sformatf("v%0d_lo", i), lo, vt[i].elo);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
    end

    mthi = 1'b1; wd = 32'h11;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; wd = 32'h22;
    chk("mthi_hi", hi, 32'h11);
    chk("mthi_busy", busy, 0);
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'h22);
    chk("mtlo_done", done, 0);

    @(negedge clk);
    op = 2'b01; srca = 32'd3; srcb = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    op = 2'b00; srca = 32'd7; srcb = 32'd7;
    start = 1'b1; mthi = 1'b1; wd = 32'hAA;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("busy_hi_stable", hi, 32'h11);
    wait_idle(n, dn);
    chk("ign_done", done, 1);
    chk("ign_pulses", dn, 0);
    chk("ign_hi", hi, 0);
    chk("ign_lo", lo, 15);
    op = 2'b01; srca = 32'd7; srcb = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done", busy, 1);
    wait_idle(n, dn);
    chk("sid_cycles", n, 33);
    chk("sid_lo", lo, 49);
    chk("sid_hi", hi, 0);

    op = 2'b01; srca = 32'd2; srcb = 32'd3;
    start = 1'b1; mthi = 1'b1; wd = 32'hBB;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("start_wins_hi", hi, 0);
    chk("start_wins_busy", busy, 1);
    repeat (3) @(negedge clk);
    mtlo = 1'b1; wd = 32'hCC;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_busy_ign", lo, 49);
    wait_idle(n, dn);
    chk("sw_lo", lo, 6);
    chk("sw_hi", hi, 0);

    mtlo = 1'b1; wd = 32'h55;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo55", lo, 32'h55);
    op = 2'b01; srca = 32'd3; srcb = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_lo_after", lo, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
